// File: rtl/wb_dual_master_arbiter_if.sv
// Bus bundle for the two-master Wishbone arbiter: master-side ports,
// shared slave-side ports and the grant observability vector.
interface wb_dual_master_arbiter_if;
    logic [31:0]  m0_data_i;
    logic [31:0]  m0_data_o;
    logic [31:0]  m0_addr_i;
    logic [3:0]   m0_sel_i;
    logic         m0_we_i;
    logic         m0_cyc_i;
    logic         m0_stb_i;
    logic         m0_ack_o;
    logic         m0_err_o;

    logic [31:0]  m1_data_i;
    logic [31:0]  m1_data_o;
    logic [31:0]  m1_addr_i;
    logic [3:0]   m1_sel_i;
    logic         m1_we_i;
    logic         m1_cyc_i;
    logic         m1_stb_i;
    logic         m1_ack_o;
    logic         m1_err_o;

    logic [31:0]  s_data_o;
    logic [31:0]  s_addr_o;
    logic [3:0]   s_sel_o;
    logic         s_we_o;
    logic [3:0]   s_cyc_o;
    logic [3:0]   s_stb_o;
    logic [3:0]   s_ack_i;
    logic [127:0] s_data_i;
    logic [1:0]   grant_o;

    // Arbiter side of the bundle
    modport slave (
        input  m0_data_i, m0_addr_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i,
        output m0_data_o, m0_ack_o, m0_err_o,
        input  m1_data_i, m1_addr_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i,
        output m1_data_o, m1_ack_o, m1_err_o,
        output s_data_o, s_addr_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
        input  s_ack_i, s_data_i,
        output grant_o
    );

    // Environment side: the two masters plus the slave population
    modport master (
        output m0_data_i, m0_addr_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i,
        input  m0_data_o, m0_ack_o, m0_err_o,
        output m1_data_i, m1_addr_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i,
        input  m1_data_o, m1_ack_o, m1_err_o,
        input  s_data_o, s_addr_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
        output s_ack_i, s_data_i,
        input  grant_o
    );
endinterface

// File: rtl/wb_dual_master_arbiter.sv
// Round-robin Wishbone classic arbiter for two masters onto four slaves,
// with address decode, unmapped-address error and slave-hang timeout.
module wb_dual_master_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    wb_dual_master_arbiter_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_e;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    logic        req0, req1;
    logic        busy, own0, own1;
    logic [31:0] o_addr, o_wdat;
    logic [3:0]  o_sel;
    logic        o_we, o_cyc, o_stb;
    logic        mapped;
    logic [3:0]  dec_oh;
    logic        ack;
    logic [31:0] rdata;

    assign req0 = bus.m0_cyc_i & bus.m0_stb_i;
    assign req1 = bus.m1_cyc_i & bus.m1_stb_i;
    assign busy = (state_q != IDLE);
    assign own0 = (state_q == BUSY0);
    assign own1 = (state_q == BUSY1);

    always_comb begin
        o_addr = own1 ? bus.m1_addr_i : bus.m0_addr_i;
        o_wdat = own1 ? bus.m1_data_i : bus.m0_data_i;
        o_sel  = own1 ? bus.m1_sel_i  : bus.m0_sel_i;
        o_we   = own1 ? bus.m1_we_i   : bus.m0_we_i;
        o_cyc  = own1 ? bus.m1_cyc_i  : bus.m0_cyc_i;
        o_stb  = own1 ? bus.m1_stb_i  : bus.m0_stb_i;
    end

    assign mapped = (o_addr[31:28] < 4'd4);
    assign dec_oh = mapped ? (4'b0001 << o_addr[29:28]) : 4'b0000;
    assign rdata  = mapped ? bus.s_data_i[{o_addr[29:28], 5'd0} +: 32] : 32'd0;
    // Ack is suppressed in an error cycle so the two never reach a master together
    assign ack    = busy & (|(bus.s_ack_i & dec_oh)) & ~err_q;

    always_comb begin
        bus.s_cyc_o  = (busy & o_cyc) ? dec_oh : 4'b0000;
        bus.s_stb_o  = (busy & o_cyc & o_stb & ~err_q) ? dec_oh : 4'b0000;
        bus.s_addr_o = busy ? o_addr : 32'd0;
        bus.s_data_o = busy ? o_wdat : 32'd0;
        bus.s_sel_o  = busy ? o_sel  : 4'b0000;
        bus.s_we_o   = busy & o_we;
        bus.m0_ack_o  = own0 & ack;
        bus.m0_err_o  = own0 & err_q;
        bus.m0_data_o = own0 ? rdata : 32'd0;
        bus.m1_ack_o  = own1 & ack;
        bus.m1_err_o  = own1 & err_q;
        bus.m1_data_o = own1 ? rdata : 32'd0;
        bus.grant_o   = {own1, own0};
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = '0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // last_q set means m1 went last, so m0 takes a tie
                if (req0 && (!req1 || last_q)) begin
                    state_d = BUSY0;
                    last_d  = 1'b0;
                end else if (req1) begin
                    state_d = BUSY1;
                    last_d  = 1'b1;
                end
            end
            default: begin
                if (!o_cyc) begin
                    state_d = IDLE;
                end else if (o_stb && !err_q) begin
                    if (!mapped) begin
                        err_d = 1'b1;
                    end else if (!ack) begin
                        if (cnt_q == TO_LAST) err_d = 1'b1;
                        else cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule
